// File: rtl/exec_wb_unit.sv
// Execute/write-back stage: single-cycle ALU ops plus an iterative shift-add multiplier.
// Define EXEC_WB_ZERO_REG_EN to suppress the write strobe for results aimed at register 0.
module exec_wb_unit #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int MUL_STEP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [2:0]        op,
  input  logic [REG_AW-1:0] rd,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic [0:0]        state_dbg
);

  localparam int N     = DATA_W / MUL_STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int SH_W  = $clog2(DATA_W);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

`ifdef EXEC_WB_ZERO_REG_EN
  localparam bit ZERO_REG_EN = 1'b1;
`else
  localparam bit ZERO_REG_EN = 1'b0;
`endif

  // Handshake: a request transfers on a rising edge where issue_valid and
  // issue_ready are both high; issue_ready depends only on the state flop.
  logic [0:0]        state;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] pp;
  logic [DATA_W-1:0] alu_res;
  logic [REG_AW-1:0] mul_rd;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              alu_wr_ok;
  logic              mul_wr_ok;

  assign issue_ready = (state == ST_IDLE);
  assign busy        = (state == ST_MUL);
  assign state_dbg   = state;
  assign accept      = issue_valid & issue_ready;
  assign alu_wr_ok   = !(ZERO_REG_EN && (rd == '0));
  assign mul_wr_ok   = !(ZERO_REG_EN && (mul_rd == '0));

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = opa + opb;
      OP_SUB:  alu_res = opa - opb;
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(opa) < $signed(opb))};
      OP_SLL:  alu_res = opa << opb[SH_W-1:0];
      default: alu_res = '0;
    endcase
  end

  // mcand is pre-shifted every step, so this partial product is already aligned to acc.
  always_comb begin
    pp = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (mplier[i]) pp = pp + (mcand << i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      wb_en   <= 1'b0;
      wb_reg  <= '0;
      wb_data <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      mul_rd  <= '0;
    end else begin
      wb_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              mcand  <= opa;
              mplier <= opb;
              acc    <= '0;
              cnt    <= '0;
              mul_rd <= rd;
              state  <= ST_MUL;
            end else begin
              wb_en   <= alu_wr_ok;
              wb_reg  <= rd;
              wb_data <= alu_res;
            end
          end
        end
        ST_MUL: begin
          acc    <= acc + pp;
          mcand  <= mcand << MUL_STEP;
          mplier <= mplier >> MUL_STEP;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(N - 1)) begin
            wb_en   <= mul_wr_ok;
            wb_reg  <= mul_rd;
            wb_data <= acc + pp;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_wb_unit.sv
// Bench for exec_wb_unit: directed cases plus random ops against an arithmetic reference model;
// a negedge monitor pops expected writes (register, data, cycle) from the scoreboard queues.
module tb_exec_wb_unit;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int N1 = 32;
  localparam int N4 = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

`ifdef EXEC_WB_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (MUL_STEP = 1) ----------------
  logic          issue_valid = 1'b0;
  logic          issue_ready;
  logic [2:0]    op = '0;
  logic [AW-1:0] rd = '0;
  logic [W-1:0]  opa = '0, opb = '0;
  logic          wb_en, busy;
  logic [AW-1:0] wb_reg;
  logic [W-1:0]  wb_data;
  logic [0:0]    state_dbg;

  exec_wb_unit #(.DATA_W(W), .REG_AW(AW), .MUL_STEP(1)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .op(op), .rd(rd), .opa(opa), .opb(opb), .wb_en(wb_en), .wb_reg(wb_reg),
    .wb_data(wb_data), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- second DUT (MUL_STEP = 4) ----------------
  logic          v4 = 1'b0;
  logic          ready4;
  logic [2:0]    op4 = '0;
  logic [AW-1:0] rd4 = '0;
  logic [W-1:0]  a4 = '0, b4 = '0;
  logic          wb_en4, busy4;
  logic [AW-1:0] wb_reg4;
  logic [W-1:0]  wb_data4;
  logic [0:0]    state_dbg4;

  exec_wb_unit #(.DATA_W(W), .REG_AW(AW), .MUL_STEP(4)) dut4 (
    .clk(clk), .reset(reset), .issue_valid(v4), .issue_ready(ready4),
    .op(op4), .rd(rd4), .opa(a4), .opb(b4), .wb_en(wb_en4), .wb_reg(wb_reg4),
    .wb_data(wb_data4), .busy(busy4), .state_dbg(state_dbg4)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] exp_reg_q[$];
  int            exp_cyc_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the architectural result of each op, written as plain arithmetic.
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned prod;
    int              sa, sb;
    sa = a;
    sb = b;
    prod = longint'(a) * longint'(b);
    case (o)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sa < sb) ? W'(1) : W'(0);
      3'd6: return prod[W-1:0];
      default: return a << (b % W);
    endcase
  endfunction

  // Driver: present a request, wait for issue_ready, push the expected write.
  // Latency is counted in cycles from the accepting cycle: 1 for ALU ops, N+1 for MUL.
  task automatic issue(input logic [2:0] o, input logic [AW-1:0] r, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit expect_wb);
    int guard;
    int acc_cyc;
    guard = 0;
    op = o; rd = r; opa = a; opb = b; issue_valid = 1'b1;
    @(negedge clk);
    while (!issue_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!issue_ready) begin
      total++; bad++;
      $display("FAIL issue_wait: issue_ready=0 after %0d cycles, want 1", guard);
      issue_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    if (expect_wb && !(ZR && r == '0)) begin
      exp_q.push_back(model(o, a, b));
      exp_reg_q.push_back(r);
      exp_cyc_q.push_back(acc_cyc + ((o == OP_MUL) ? N1 + 1 : 1));
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    issue_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0]  mon_d;
  logic [AW-1:0] mon_r;
  int            mon_c;
  always @(negedge clk) begin
    if (reset) begin
      if (wb_en) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_wb: got reg %0d data 0x%08h, want no write", wb_reg, wb_data);
        end else begin
          mon_d = exp_q.pop_front();
          mon_r = exp_reg_q.pop_front();
          mon_c = exp_cyc_q.pop_front();
          check("wb_data", wb_data, mon_d);
          check("wb_reg", W'(wb_reg), W'(mon_r));
          check("wb_cycle", W'(cyc), W'(mon_c));
        end
      end else if (exp_cyc_q.size() > 0 && cyc >= exp_cyc_q[0]) begin
        total++; bad++;
        $display("FAIL missing_wb: got wb_en=0 at cycle %0d, want write to reg %0d data 0x%08h",
                 cyc, exp_reg_q[0], exp_q[0]);
        void'(exp_q.pop_front());
        void'(exp_reg_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] edge_vals[4];
  initial begin
    int acc4, guard;
    logic [2:0]    o;
    logic [AW-1:0] r;
    logic [W-1:0]  a, b;
    edge_vals[0] = 32'h0000_0000; edge_vals[1] = 32'hFFFF_FFFF;
    edge_vals[2] = 32'h8000_0000; edge_vals[3] = 32'h7FFF_FFFF;

    // Power-on reset values
    repeat (3) @(posedge clk); #1;
    check("rst_wb_en", W'(wb_en), '0);
    check("rst_wb_reg", W'(wb_reg), '0);
    check("rst_wb_data", wb_data, '0);
    check("rst_busy", W'(busy), '0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", W'(issue_ready), W'(1));

    // Back-to-back single-cycle ops
    issue(OP_ADD, 5'd3, 32'd7, 32'd5, 1'b1);
    issue(OP_SUB, 5'd4, 32'd5, 32'd7, 1'b1);
    issue(OP_SLT, 5'd5, 32'hFFFF_FFFF, 32'd1, 1'b1);
    issue(OP_SLL, 5'd6, 32'd1, 32'h21, 1'b1);
    idle(3);

    // Mid-simulation reset
    reset = 1'b0; #1;
    check("mid_rst_wb_en", W'(wb_en), '0);
    check("mid_rst_wb_reg", W'(wb_reg), '0);
    check("mid_rst_wb_data", wb_data, '0);
    check("mid_rst_busy", W'(busy), '0);
    check("mid_rst_ready", W'(issue_ready), W'(1));
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // MUL with issue_valid held high throughout: nothing else may be accepted
    issue(OP_MUL, 5'd7, 32'h0001_0003, 32'h0000_0005, 1'b1);
    op = OP_ADD; rd = 5'd9; opa = 32'd1; opb = 32'd1; issue_valid = 1'b1;
    for (int i = 0; i < N1; i++) begin
      @(negedge clk);
      check("mul_busy", W'({busy, issue_ready}), W'(2'b10));
      if (i == N1 - 1) issue_valid = 1'b0;
    end
    @(posedge clk); #1;

    // All-ones multiply on both step widths
    issue(OP_MUL, 5'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue_valid = 1'b0;
    op4 = OP_MUL; rd4 = 5'd11; a4 = 32'hFFFF_FFFF; b4 = 32'hFFFF_FFFF; v4 = 1'b1;
    @(negedge clk);
    acc4 = cyc;
    check("step4_ready", W'(ready4), W'(1));
    @(posedge clk); #1;
    v4 = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!wb_en4 && guard < 30);
    if (!wb_en4) begin
      total++; bad++;
      $display("FAIL step4_timeout: got wb_en=0 after %0d cycles, want a write", guard);
    end else begin
      check("step4_data", wb_data4, 32'h0000_0001);
      check("step4_reg", W'(wb_reg4), W'(11));
      check("step4_latency", W'(cyc - acc4), W'(N4 + 1));
    end
    @(posedge clk); #1;
    idle(40);

    // Reset during a multiply discards it; the unit then works normally
    issue(OP_MUL, 5'd12, $urandom, $urandom, 1'b0);
    issue_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0; #1;
    check("mul_rst_wb_en", W'(wb_en), '0);
    check("mul_rst_busy", W'(busy), '0);
    check("mul_rst_ready", W'(issue_ready), W'(1));
    @(negedge clk) reset = 1'b1;
    idle(40);
    issue(OP_ADD, 5'd2, 32'd1, 32'd1, 1'b1);
    issue_valid = 1'b0;
    idle(2);

    // Write to register 0
    issue(OP_ADD, 5'd0, 32'd3, 32'd4, 1'b1);
    issue_valid = 1'b0;
    @(negedge clk);
    check("r0_wb_en", W'(wb_en), W'(!ZR));
    check("r0_wb_reg", W'(wb_reg), '0);
    check("r0_wb_data", wb_data, 32'd7);
    @(posedge clk); #1;

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      o = 3'($urandom_range(0, 7));
      if (o == OP_MUL && $urandom_range(0, 2) != 0) o = OP_SUB;
      r = 5'($urandom_range(0, 31));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = edge_vals[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) b = edge_vals[$urandom_range(0, 3)];
      issue(o, r, a, b, 1'b1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    issue_valid = 1'b0;

    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    check("drain_empty", W'(exp_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
